// File: rtl/alu4_pkg.sv
// Shared types and constants for the alu4 issue stage.
package alu4_pkg;

    // Opcodes whose high result nibble is meaningful
    localparam logic [3:0] OP_ADD      = 4'd14;
    localparam logic [3:0] OP_SUB      = 4'd15;
    localparam logic [3:0] OP_WIDE_MIN = 4'd14;

    // Issue FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // One queued ALU command
    typedef struct packed {
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/alu4_cmd_fifo.sv
// Small synchronous FIFO holding commands waiting to be issued to the ALU.
// Pushes while full and pops while empty are ignored.
module alu4_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LW-1:0]    level_r;
    logic             full_s;
    logic             empty_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Status flags and qualified push/pop strobes
    always_comb begin
        full_s    = (level_r == LW'(DEPTH));
        empty_s   = (level_r == {LW{1'b0}});
        push_ok_s = push && !full_s;
        pop_ok_s  = pop && !empty_s;
    end

    // Storage array: written at the tail on every accepted push
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
        end
    end

    // Occupancy count; simultaneous push and pop leaves it unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            level_r <= {LW{1'b0}};
        end else begin
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + 1'b1;
                2'b01:   level_r <= level_r - 1'b1;
                default: level_r <= level_r;
            endcase
        end
    end

    assign head_data = mem_r[rd_ptr_r];
    assign full      = full_s;
    assign empty     = empty_s;
    assign level     = level_r;

endmodule

// File: rtl/alu4_issue.sv
// Command queue and issue stage in front of the combinational alu4.
// Commands are buffered, driven one at a time onto registered ALU inputs,
// and the ALU result is captured one cycle later and held until consumed.
module alu4_issue
    import alu4_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [3:0]    cmd_op,
    input  logic [3:0]    cmd_a,
    input  logic [3:0]    cmd_b,
    output logic [3:0]    alu_a,
    output logic [3:0]    alu_b,
    output logic [3:0]    alu_op,
    input  logic [3:0]    alu_x,
    input  logic [3:0]    alu_y,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [3:0]    res_op,
    output logic [3:0]    res_x,
    output logic [3:0]    res_y,
    output logic          res_zero,
    output logic [LW-1:0] fifo_level,
    output logic          busy
);

    state_t           state_r;
    state_t           state_nx_s;
    logic             pop_s;
    logic             push_s;
    logic             cmd_ready_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [LW-1:0]    fifo_level_s;
    logic [CMD_W-1:0] head_data_s;
    cmd_t             head_cmd_s;
    cmd_t             push_cmd_s;
    logic [3:0]       res_y_s;

    logic [3:0]       alu_a_r;
    logic [3:0]       alu_b_r;
    logic [3:0]       alu_op_r;
    logic             res_valid_r;
    logic [3:0]       res_op_r;
    logic [3:0]       res_x_r;
    logic [3:0]       res_y_r;
    logic             res_zero_r;

    // Input handshake; space freed by a same-cycle pop is not reused
    always_comb begin
        cmd_ready_s = !rst && (fifo_level_s != LW'(DEPTH));
        push_s      = cmd_valid && cmd_ready_s;
        push_cmd_s  = '{op: cmd_op, a: cmd_a, b: cmd_b};
        head_cmd_s  = cmd_t'(head_data_s);
    end

    alu4_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W),
        .LW    (LW)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (push_cmd_s),
        .pop       (pop_s),
        .head_data (head_data_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .level     (fifo_level_s)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next state and pop decision; a pop always loads the ALU registers
    always_comb begin
        state_nx_s = state_r;
        pop_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s      = 1'b1;
                    state_nx_s = ISSUE;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            ISSUE: begin
                state_nx_s = HOLD;
            end
            HOLD: begin
                if (res_ready) begin
                    if (!fifo_empty_s) begin
                        pop_s      = 1'b1;
                        state_nx_s = ISSUE;
                    end else begin
                        state_nx_s = IDLE;
                    end
                end else begin
                    state_nx_s = HOLD;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // ALU operand registers: loaded on pop, otherwise keep last command
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a_r  <= 4'd0;
            alu_b_r  <= 4'd0;
            alu_op_r <= 4'd0;
        end else if (pop_s) begin
            alu_a_r  <= head_cmd_s.a;
            alu_b_r  <= head_cmd_s.b;
            alu_op_r <= head_cmd_s.op;
        end else begin
            alu_a_r  <= alu_a_r;
            alu_b_r  <= alu_b_r;
            alu_op_r <= alu_op_r;
        end
    end

    // High nibble only carries information for the wide add/sub opcodes
    always_comb begin
        if (alu_op_r >= OP_WIDE_MIN) begin
            res_y_s = alu_y;
        end else begin
            res_y_s = 4'd0;
        end
    end

    // Result register: captured at the end of ISSUE, held until consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_r <= 1'b0;
            res_op_r    <= 4'd0;
            res_x_r     <= 4'd0;
            res_y_r     <= 4'd0;
            res_zero_r  <= 1'b1;
        end else if (state_r == ISSUE) begin
            res_valid_r <= 1'b1;
            res_op_r    <= alu_op_r;
            res_x_r     <= alu_x;
            res_y_r     <= res_y_s;
            res_zero_r  <= ({res_y_s, alu_x} == 8'h00);
        end else if ((state_r == HOLD) && res_ready) begin
            res_valid_r <= 1'b0;
        end else begin
            res_valid_r <= res_valid_r;
        end
    end

    assign cmd_ready  = cmd_ready_s;
    assign alu_a      = alu_a_r;
    assign alu_b      = alu_b_r;
    assign alu_op     = alu_op_r;
    assign res_valid  = res_valid_r;
    assign res_op     = res_op_r;
    assign res_x      = res_x_r;
    assign res_y      = res_y_r;
    assign res_zero   = res_zero_r;
    assign fifo_level = fifo_level_s;
    assign busy       = (state_r != IDLE) || (fifo_level_s != {LW{1'b0}}) || (fifo_full_s && 1'b0);

endmodule

// File: doc/alu4_issue.md
# alu4_issue

Command-queue and issue stage placed directly upstream of the combinational `alu4` datapath. It accepts operations `{op, a, b}` over a valid/ready handshake and buffers them in a small FIFO. It drives them one at a time onto the ALU's `a`/`b`/`opcode` inputs, captures the ALU's `{y,x}` result one cycle later, and presents it downstream over a valid/ready handshake.

## Interface
Parameters:
- `DEPTH`, 4: command FIFO depth, power of two, ≥2.
- `LW`, `$clog2(DEPTH+1)`: width of `fifo_level`.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`.
- `cmd_op`  in  4  ALU opcode.
- `cmd_a`  in  4  operand a.
- `cmd_b`  in  4  operand b.
- `alu_a`  out  4  registered, to `alu4.a`.
- `alu_b`  out  4  registered, to `alu4.b`.
- `alu_op`  out  4  registered, to `alu4.opcode`.
- `alu_x`  in  4  from `alu4.x`.
- `alu_y`  in  4  from `alu4.y`.
- `res_valid`  out  1  result present.
- `res_ready`  in  1  result consumed when `res_valid && res_ready`.
- `res_op`  out  4  opcode of the presented result.
- `res_x`  out  4  low result nibble.
- `res_y`  out  4  high result nibble; forced to 0 for opcodes 0–13.
- `res_zero`  out  1  `{res_y,res_x} == 0`.
- `fifo_level`  out  `LW`  number of queued, not-yet-issued commands.
- `busy`  out  1  state ≠ IDLE or `fifo_level` ≠ 0.

## Operation
- FIFO stores 12-bit `{op,a,b}` entries.
  - Push when `cmd_valid && cmd_ready`.
  - `cmd_ready = !rst && (fifo_level != DEPTH)`. A pop in the same cycle does not free space for that cycle's push.
  - Push and pop in the same cycle leave `fifo_level` unchanged.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop; load `alu_a/alu_b/alu_op` from the head entry; go to ISSUE. Otherwise stay.
  - ISSUE: ALU inputs are stable this whole cycle. At the clock edge, capture the result:
    - `res_x ← alu_x`.
    - `res_y ← (alu_op ≥ 14) ? alu_y : 0`.
    - `res_op ← alu_op`.
    - `res_valid ← 1`.
    - Go to HOLD.
  - HOLD: `res_*` are held stable while `res_valid && !res_ready`. On `res_ready`:
    - `res_valid` drops.
    - If the FIFO is non-empty, pop and load the ALU registers, then go to ISSUE.
    - Otherwise go to IDLE.
- `alu_*` registers keep their last value when idle; they are not cleared.
- Arithmetic is owned by `alu4`. This block only masks `res_y`.
  - Opcode 14: `{y,x}` is the 8-bit `a+b`.
  - Opcode 15: `{y,x}` is the 8-bit two's-complement `a−b`.
- Reset values:
  - State IDLE; `fifo_level` 0.
  - `res_valid` 0; `res_x`, `res_y`, `res_op` 0; `res_zero` 1.
  - `alu_a`, `alu_b`, `alu_op` 0; `busy` 0; `cmd_ready` 0 while `rst` is high.
- Reset mid-operation discards all queued and in-flight commands. No partial result is ever presented after reset.

## Timing
- Command accepted in cycle t:
  - Visible in the FIFO at t+1; popped at t+1 if IDLE.
  - ISSUE at t+2.
  - `res_valid` high at t+3. Minimum latency is 3 cycles.
- Steady-state throughput is one result per 2 cycles (ISSUE, HOLD) when `res_ready` is held high.
- `res_valid` never drops without a handshake.
- `res_*` do not change while `res_valid && !res_ready`.
- Capacity with the output stalled is DEPTH + 1 commands: DEPTH queued plus one in the result register.

## Structure
- `alu4_pkg`:
  - Opcode constants: `OP_ADD = 4'd14`, `OP_SUB = 4'd15`, `OP_WIDE_MIN = 4'd14`.
  - FSM state enum: `IDLE`, `ISSUE`, `HOLD`.
  - Command struct `{op,a,b}`.
- Sub-module `alu4_cmd_fifo`: parameterised synchronous FIFO with push, pop, full, empty, level and head data. The FSM and result registers live in `alu4_issue`.
- `alu4` is instantiated by the parent, not inside this block.

## Test plan
- Reset, then a single command: op 14, a=9, b=8, `res_ready`=1.
  - Required: `res_valid` at t+3 with `res_y`=1, `res_x`=1, `res_zero`=0.
  - Required: `res_valid` low the following cycle.
- op 15, a=3, b=5.
  - Required: `res_y`=F, `res_x`=E.
- op 10, a=A, b=6, with the ALU driving junk on `y`.
  - Required: `res_x`=C, `res_y`=0.
- Push 6 back-to-back with `res_ready`=0.
  - Required: 5 accepted, `cmd_ready` low, `fifo_level`=4.
  - Then release `res_ready`. Required: 5 results in order, spaced 2 cycles apart.
- Hold `res_ready`=0 for 10 cycles on a pending result.
  - Required: `res_*` stable; the result is consumed exactly once.
- Assert `rst` while in ISSUE with 3 commands queued.
  - Required next cycle: `res_valid`=0, `fifo_level`=0, `busy`=0.
  - Required: no result is emitted afterwards.
